// File: rtl/pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_pkg
//   Shared CPU-wide constants used by the fetch address generator:
//   reset / chip-enable / stall polarities and the instruction address bus
//   width. Imported by pc_gen.
// ---------------------------------------------------------------------------
package pc_gen_pkg;

  // Reset polarity of the core (active-high).
  localparam logic RstEnable   = 1'b1;
  localparam logic RstDisable  = 1'b0;

  // Instruction memory enable levels.
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  // Stall vector bit levels.
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;

  // Instruction address bus width.
  localparam int unsigned InstAddrBusW = 32;

endpackage : pc_gen_pkg

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
//   Program counter / fetch address generator. After reset it issues
//   RESET_VEC, then walks sequentially by INC bytes whenever the fetch
//   advances (stall[0] clear and memory ready). Redirects are prioritised
//   flush > branch > stored redirect > increment > hold. A branch that
//   arrives while the fetch cannot advance is parked in pend_pc (state HOLD)
//   and applied on the next advance.
//
// Ports
//   clk                     : clock, rising edge
//   rst                     : synchronous active-high reset
//   stall[STALL_W]          : pipeline stall vector, bit 0 freezes the PC
//   flush, new_pc           : exception/ERET redirect and its target
//   branch_flag_i           : branch/jump taken from ID
//   branch_target_address_i : branch target
//   mem_ready_i             : instruction memory accepted pc this cycle
//   pc, ce                  : registered fetch address and memory enable
//   fetch_stall_o           : fetch waiting on memory (ce=1, not ready)
//   redirect_pending_o      : a captured branch target is waiting
// ---------------------------------------------------------------------------
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned         ADDR_W    = InstAddrBusW,
  parameter logic [ADDR_W-1:0]   RESET_VEC = {ADDR_W{1'b0}},
  parameter int unsigned         INC       = 4,
  parameter int unsigned         STALL_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   new_pc,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_target_address_i,
  input  logic                mem_ready_i,
  output logic [ADDR_W-1:0]   pc,
  output logic                ce,
  output logic                fetch_stall_o,
  output logic                redirect_pending_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pend_q, pend_d;
  logic                ce_q, ce_d;
  logic                advance_s;
  logic                unused_stall_s;

  // Only bit 0 of the stall vector concerns the fetch stage.
  assign unused_stall_s = ^stall[STALL_W-1:1];

  assign advance_s = (stall[0] == NoStop) && mem_ready_i;

  // Next-state, next-pc and pending-target selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ce_d    = ce_q;
    case (state_q)
      ST_IDLE: begin
        // Redirects and stalls are ignored until the first fetch is issued.
        state_d = ST_RUN;
        ce_d    = ChipEnable;
        pc_d    = RESET_VEC;
        pend_d  = {ADDR_W{1'b0}};
      end
      ST_RUN, ST_HOLD: begin
        ce_d = ChipEnable;
        if (flush) begin
          pc_d    = new_pc;
          pend_d  = {ADDR_W{1'b0}};
          state_d = ST_RUN;
        end else if (branch_flag_i) begin
          if (advance_s) begin
            // A fresh branch supersedes any older parked target.
            pc_d    = branch_target_address_i;
            pend_d  = {ADDR_W{1'b0}};
            state_d = ST_RUN;
          end else begin
            pend_d  = branch_target_address_i;
            state_d = ST_HOLD;
          end
        end else if (state_q == ST_HOLD) begin
          if (advance_s) begin
            pc_d    = pend_q;
            pend_d  = {ADDR_W{1'b0}};
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          if (advance_s) begin
            pc_d = pc_q + INC_V;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      default: begin
        // Illegal encoding: fall back to the post-reset state.
        state_d = ST_IDLE;
        ce_d    = ChipDisable;
        pc_d    = RESET_VEC;
        pend_d  = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, pc, enable and pending-target registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VEC;
      ce_q    <= ChipDisable;
      pend_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= ce_d;
      pend_q  <= pend_d;
    end
  end

  assign pc                 = pc_q;
  assign ce                 = ce_q;
  assign fetch_stall_o      = ce_q & ~mem_ready_i;
  assign redirect_pending_o = (state_q == ST_HOLD);

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen
//   Directed scoreboard bench for pc_gen. A 32-bit instance covers reset,
//   sequencing, stalls, branch parking, flush priority and reset during HOLD;
//   a 16-bit instance covers a non-zero reset vector and address wrap.
// ---------------------------------------------------------------------------
module tb_pc_gen;

  logic        clk;

  logic        rst, flush, br, mr;
  logic [5:0]  stall;
  logic [31:0] new_pc, bt;
  logic [31:0] pc;
  logic        ce, fs, rp;

  logic        rst16, flush16, br16, mr16;
  logic [5:0]  stall16;
  logic [15:0] new_pc16, bt16;
  logic [15:0] pc16;
  logic        ce16, fs16, rp16;

  typedef struct {
    int          due;
    bit          which;
    logic [31:0] pc;
    logic        ce;
    logic        rp;
    logic        fs;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  pc_gen dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (br),
    .branch_target_address_i (bt),
    .mem_ready_i             (mr),
    .pc                      (pc),
    .ce                      (ce),
    .fetch_stall_o           (fs),
    .redirect_pending_o      (rp)
  );

  pc_gen #(
    .ADDR_W    (16),
    .RESET_VEC (16'hFFF0),
    .INC       (4),
    .STALL_W   (6)
  ) dut16 (
    .clk                     (clk),
    .rst                     (rst16),
    .stall                   (stall16),
    .flush                   (flush16),
    .new_pc                  (new_pc16),
    .branch_flag_i           (br16),
    .branch_target_address_i (bt16),
    .mem_ready_i             (mr16),
    .pc                      (pc16),
    .ce                      (ce16),
    .fetch_stall_o           (fs16),
    .redirect_pending_o      (rp16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, expv);
    end
  endtask

  // Monitor: after each rising edge, compare every entry due this cycle.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due < cyc) begin
        total++;
        bad++;
        $display("FAIL %s.late: due %0d checked %0d", e.name, e.due, cyc);
      end else if (e.which) begin
        chk(e.name, "pc", {16'h0000, pc16}, e.pc);
        chk(e.name, "ce", {31'd0, ce16}, {31'd0, e.ce});
        chk(e.name, "rp", {31'd0, rp16}, {31'd0, e.rp});
        chk(e.name, "fs", {31'd0, fs16}, {31'd0, e.fs});
      end else begin
        chk(e.name, "pc", pc, e.pc);
        chk(e.name, "ce", {31'd0, ce}, {31'd0, e.ce});
        chk(e.name, "rp", {31'd0, rp}, {31'd0, e.rp});
        chk(e.name, "fs", {31'd0, fs}, {31'd0, e.fs});
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input bit which, input logic r, input logic s0, input logic fl,
                      input logic [31:0] np, input logic b, input logic [31:0] t,
                      input logic m, input logic [31:0] epc, input logic ece,
                      input logic erp, input logic efs, input string nm);
    exp_t e;
    @(negedge clk);
    if (!which) begin
      rst = r; stall = {5'b00000, s0}; flush = fl; new_pc = np; br = b; bt = t; mr = m;
    end else begin
      rst16 = r; stall16 = {5'b00000, s0}; flush16 = fl; new_pc16 = np[15:0];
      br16 = b; bt16 = t[15:0]; mr16 = m;
    end
    e.due = cyc + 1; e.which = which; e.pc = epc; e.ce = ece;
    e.rp = erp; e.fs = efs; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; flush = 1'b0; new_pc = 32'd0; br = 1'b0; bt = 32'd0; mr = 1'b1;
    rst16 = 1'b1; stall16 = 6'd0; flush16 = 1'b0; new_pc16 = 16'd0; br16 = 1'b0;
    bt16 = 16'd0; mr16 = 1'b1;

    //     w  rst s0 fl np            br  bt            mr  pc            ce   rp   fs
    // reset for three edges, then first fetch at RESET_VEC
    step(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 0, 0, "rst0");
    step(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 0, 0, "rst1");
    step(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 0, 0, "rst2");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   1, 0, 0, "first");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   1, 0, 0, "seq4");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h8,   1, 0, 0, "seq8");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hC,   1, 0, 0, "seqC");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h10,  1, 0, 0, "seq10");
    // stall[0] freezes pc for two cycles
    step(0, 0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  1, 0, 0, "stall1");
    step(0, 0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  1, 0, 0, "stall2");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h14,  1, 0, 0, "unstall");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h18,  1, 0, 0, "seq18");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h1C,  1, 0, 0, "seq1C");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h20,  1, 0, 0, "seq20");
    // branch while memory not ready is parked, applied on ready
    step(0, 0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h20,  1, 1, 1, "park1");
    step(0, 0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h20,  1, 1, 1, "park2");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 1, 0, 0, "apply");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h104, 1, 0, 0, "after");
    // flush in HOLD wins over stall and discards the parked target
    step(0, 0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h104, 1, 1, 1, "park3");
    step(0, 0, 1, 1, 32'h180, 0, 32'h0,   0, 32'h180, 1, 0, 1, "flushH");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h184, 1, 0, 0, "postfl");
    // latest parked branch wins
    step(0, 0, 1, 0, 32'h0,   1, 32'h200, 1, 32'h184, 1, 1, 0, "late1");
    step(0, 0, 1, 0, 32'h0,   1, 32'h300, 1, 32'h184, 1, 1, 0, "late2");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h300, 1, 0, 0, "latest");
    // branch with advance, then flush beats branch
    step(0, 0, 0, 0, 32'h0,   1, 32'h400, 1, 32'h400, 1, 0, 0, "brrun");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h404, 1, 0, 0, "seq404");
    step(0, 0, 0, 1, 32'h500, 1, 32'h600, 1, 32'h500, 1, 0, 0, "flprio");
    // reset while in HOLD; IDLE ignores flush/branch; parked target is gone
    step(0, 0, 0, 0, 32'h0,   1, 32'h700, 0, 32'h500, 1, 1, 1, "park4");
    step(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 0, 0, "rstH");
    step(0, 0, 0, 1, 32'h900, 1, 32'h800, 1, 32'h0,   1, 0, 0, "idleign");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   1, 0, 0, "nopend");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h4,   1, 0, 1, "memwait");
    step(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h8,   1, 0, 0, "memok");

    // 16-bit instance: RESET_VEC 0xFFF0, wrap past 0xFFFC
    step(1, 1, 0, 0, 32'h0,    0, 32'h0, 1, 32'hFFF0, 0, 0, 0, "w_rst");
    step(1, 0, 0, 0, 32'h0,    0, 32'h0, 1, 32'hFFF0, 1, 0, 0, "w_first");
    step(1, 0, 0, 0, 32'h0,    0, 32'h0, 1, 32'hFFF4, 1, 0, 0, "w_f4");
    step(1, 0, 0, 0, 32'h0,    0, 32'h0, 1, 32'hFFF8, 1, 0, 0, "w_f8");
    step(1, 0, 0, 0, 32'h0,    0, 32'h0, 1, 32'hFFFC, 1, 0, 0, "w_fc");
    step(1, 0, 0, 0, 32'h0,    0, 32'h0, 1, 32'h0000, 1, 0, 0, "w_wrap");
    step(1, 0, 0, 0, 32'h0,    0, 32'h0, 1, 32'h0004, 1, 0, 0, "w_4");
    step(1, 0, 0, 1, 32'hFFFC, 0, 32'h0, 1, 32'hFFFC, 1, 0, 0, "w_flfc");
    step(1, 0, 0, 0, 32'h0,    0, 32'h0, 1, 32'h0000, 1, 0, 0, "w_wrap2");

    // bounded drain of the scoreboard
    for (int i = 0; i < 5; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s.timeout: not checked, due %0d now %0d", e.name, e.due, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_gen
